// File: rtl/mem_access_unit.sv
// mem_access_unit: sizes, strobes and holds one dbus access per load/store, stalling the pipeline until the cache answers
package mem_access_pkg;
    localparam int DBUS_ADDR_W = 64;
    localparam int DBUS_DATA_W = 64;
    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;
    typedef struct packed {
        logic                     valid;
        logic [DBUS_ADDR_W-1:0]   addr;
        logic [2:0]               size;
        logic [DBUS_DATA_W/8-1:0] strobe;
        logic [DBUS_DATA_W-1:0]   data;
    } dbus_req_t;
    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_resp_t;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = DBUS_ADDR_W,
    parameter int DATA_W = DBUS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              fault,
    output dbus_req_t         dreq,
    input  dbus_resp_t        dresp
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W/8-1:0] strb_q, strb_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [2:0]          f3_q, f3_d;
    logic                ld_q, ld_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                acc, bad, take;
    logic [DATA_W/8-1:0] base;
    logic [DATA_W-1:0]   sh, ext;
    logic                unused_ok;

    assign unused_ok = dresp.addr_ok;

    // decode legality/alignment, build the sized request and the extended load result
    always_comb begin
        acc = req_valid & (mem_read | mem_write);
        bad = (mem_read & mem_write) | (mem_read & funct3 == 3'b111) | (mem_write & funct3[2])
            | (funct3[1:0] == 2'd1 ? addr[0] : funct3[1:0] == 2'd2 ? |addr[1:0] : funct3[1:0] == 2'd3 ? |addr[2:0] : 1'b0);
        take = state_q == IDLE & acc & ~bad;
        base = funct3[1:0] == 2'd0 ? 8'h01 : funct3[1:0] == 2'd1 ? 8'h03 : funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
        sh = dresp.data >> {addr_q[2:0], 3'b000};
        ext = f3_q[1:0] == 2'd0 ? {{(DATA_W-8){~f3_q[2] & sh[7]}}, sh[7:0]}
            : f3_q[1:0] == 2'd1 ? {{(DATA_W-16){~f3_q[2] & sh[15]}}, sh[15:0]}
            : f3_q[1:0] == 2'd2 ? {{(DATA_W-32){~f3_q[2] & sh[31]}}, sh[31:0]} : sh;
        state_d = state_q;
        addr_d = addr_q;
        size_d = size_q;
        strb_d = strb_q;
        data_d = data_q;
        f3_d = f3_q;
        ld_d = ld_q;
        rdata_d = rdata_q;
        if (take) begin
            state_d = WAIT;
            addr_d = addr;
            size_d = {1'b0, funct3[1:0]};
            strb_d = mem_read ? '0 : base << addr[2:0];
            data_d = mem_read ? '0 : wdata << {addr[2:0], 3'b000};
            f3_d = funct3;
            ld_d = mem_read;
        end else if (state_q == WAIT && dresp.data_ok) begin
            state_d = DONE;
            rdata_d = ld_q ? ext : rdata_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // outputs: request only from latched registers, stall from accept through WAIT
    always_comb begin
        stall = take | state_q == WAIT;
        fault = state_q == IDLE & acc & bad;
        rdata = rdata_q;
        rdata_valid = state_q == DONE & ld_q;
        dreq = '{valid: state_q == WAIT, addr: addr_q, size: size_q, strobe: strb_q, data: data_q};
    end

    // state and latched access registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
        addr_q <= addr_d;
        size_q <= size_d;
        strb_q <= strb_d;
        data_q <= data_d;
        f3_q <= f3_d;
        ld_q <= ld_d;
    end
endmodule
